frame_capture: RTL
==================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter ADDR_SZ, default 20, meaning RAM address width; address = {y[9:0], x[9:0]}.
REQ-002 SHALL have parameter RAM_WIDTH, default 32, meaning RAM word width.
REQ-003 SHALL have parameter MAX_W, default 1024, meaning the maximum pixels per row and the row pitch in RAM.
REQ-004 SHALL have parameter IMG_H, default 1024, meaning rows per frame; legal range 2..1024.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port mode_in, input, 1 bit: capture enable; start_in is honoured only when 1.
REQ-008 SHALL have port start_in, input, 1 bit: marks the first pixel (x=0, y=0) of a frame.
REQ-009 SHALL have port data_in, input, 24 bits: 8-bit RGB pixel, valid every cycle while capturing.
REQ-010 SHALL have port jump_in, input, 1 bit: the pixel on this cycle is x=0 of the next row.
REQ-011 SHALL have port ram_we_out, output, 1 bit: RAM write strobe.
REQ-012 SHALL have port ram_addr_out, output, ADDR_SZ bits: RAM write address.
REQ-013 SHALL have port ram_wdata_out, output, RAM_WIDTH bits: {8'h00, pixel}.
REQ-014 SHALL have port busy_out, output, 1 bit: high in the CAPTURE state.
REQ-015 SHALL have port done_out, output, 1 bit: one-cycle pulse on frame completion.
REQ-016 SHALL have port err_out, output, 1 bit: sticky protocol error, cleared by an accepted start.
REQ-017 SHALL have port width_out, output, 11 bits: row width learned from row 0.

Function
REQ-018 SHALL implement the FSM IDLE -> CAPTURE on an accepted start (start_in=1 & mode_in=1), and CAPTURE -> IDLE on completion.
REQ-019 SHALL, on an accepted start, write data_in to address 0 and set x=0, y=0, err_out=0, and width_out=0 (width unknown).
REQ-020 SHALL register all outputs, so a write appears on ram_* one cycle after its pixel is sampled.
REQ-021 SHALL, in CAPTURE with no jump_in, advance x by 1 on each pixel and write to {y, x}.
REQ-022 SHALL, on jump_in in CAPTURE, set x=0 and y=y+1 and write the pixel to {y+1, 0}; on the first jump, width_out = (last x of row 0) + 1.
REQ-023 SHALL, when a row-0 pixel would land at x=MAX_W, drop it (no write) and set err_out=1.
REQ-024 SHALL, for rows y>=1, drop any pixel at x>=width_out (no write) and set err_out=1, holding x until jump_in.
REQ-025 SHALL, on jump_in in a row y>=1 with x<width_out-1 (short row), set err_out=1 and still advance the row.
REQ-026 SHALL treat the write to {IMG_H-1, width_out-1} as the last pixel: done_out=1 in the same cycle as that ram_we_out, then enter IDLE with busy_out=0.
REQ-027 SHALL, on an accepted start while in CAPTURE, abort the frame, restart at address 0, and set err_out=1 for the new frame (truncation).
REQ-028 SHALL give start_in priority over a simultaneous jump_in; the jump is ignored.
REQ-029 SHALL ignore jump_in and data_in while in IDLE, with no writes.
REQ-030 SHALL ignore start_in while mode_in=0 in both states; an ongoing capture continues.

Reset
REQ-031 SHALL, while rst_n_in=0, force immediately: state IDLE, x=y=0, ram_we_out=0, ram_addr_out=0, ram_wdata_out=0, busy_out=0, done_out=0, err_out=0, width_out=0.
REQ-032 SHALL abandon any capture interrupted by reset, with no further writes; the next accepted start captures normally.

Verification
REQ-033 SHALL be tested: rst_n_in=0 mid-cycle -> all outputs 0 without waiting for a clock edge.
REQ-034 SHALL be tested with IMG_H=4: mode_in=1, start with data 0x112233, 12 pixels, jump on pixels 4, 7, 10 -> writes to 0x00000-0x00002, 0x00400-0x00402, 0x00800-0x00802, 0x00C00-0x00C02; first wdata 0x00112233; width_out=3; done_out pulses with the 0x00C02 write; err_out=0.
REQ-035 SHALL be tested: start_in=1 with mode_in=0 -> no ram_we_out, busy_out stays 0.
REQ-036 SHALL be tested: a second start after 5 pixels -> next write at 0x00000, err_out=1, and done_out only after a full new frame.
REQ-037 SHALL be tested: with width 3, a fourth pixel in row 1 without jump -> no write for that pixel, err_out=1, and the jump then writes 0x00800.
REQ-038 SHALL be tested: start coincident with jump_in -> write at 0x00000, y stays 0.

Source files
------------

// File: rtl/frame_capture.sv
// Streams a raster frame into RAM. Pixel coordinates are tracked as the pixels
// arrive, row 0 sets the row width, and every later row is checked against it.
module frame_capture #(
    parameter int ADDR_SZ   = 20,
    parameter int RAM_WIDTH = 32,
    parameter int MAX_W     = 1024,
    parameter int IMG_H     = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 mode_in,
    input  logic                 start_in,
    input  logic [23:0]          data_in,
    input  logic                 jump_in,
    output logic                 ram_we_out,
    output logic [ADDR_SZ-1:0]   ram_addr_out,
    output logic [RAM_WIDTH-1:0] ram_wdata_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 err_out,
    output logic [10:0]          width_out
);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    localparam logic [10:0] ROW_LIMIT = 11'(MAX_W);
    localparam logic [10:0] LAST_Y    = 11'(IMG_H - 1);

    state_t state, state_nxt;

    logic [10:0] x, x_nxt;
    logic [10:0] y, y_nxt;
    logic [10:0] width_nxt;
    logic [10:0] x_inc;
    logic [10:0] wx, wy;
    logic        we_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic        start_ok;

    logic [ADDR_SZ-1:0]   addr_nxt;
    logic [RAM_WIDTH-1:0] wdata_nxt;

    assign start_ok  = start_in & mode_in;
    assign x_inc     = x + 11'd1;
    assign addr_nxt  = ADDR_SZ'({wy[9:0], wx[9:0]});
    assign wdata_nxt = RAM_WIDTH'({8'h00, data_in});

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        width_nxt = width_out;
        err_nxt   = err_out;
        we_nxt    = 1'b0;
        done_nxt  = 1'b0;
        wx        = x;
        wy        = y;

        if (start_ok) begin
            // A start during capture truncates the frame being written.
            state_nxt = CAPTURE;
            x_nxt     = 11'd0;
            y_nxt     = 11'd0;
            width_nxt = 11'd0;
            err_nxt   = (state == CAPTURE);
            we_nxt    = 1'b1;
            wx        = 11'd0;
            wy        = 11'd0;
        end else if (state == CAPTURE) begin
            if (jump_in) begin
                if (y == LAST_Y) begin
                    // Jumping out of the last row means the frame was malformed.
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (y == 11'd0) begin
                        width_nxt = x_inc;
                    end else if (x_inc < width_out) begin
                        err_nxt = 1'b1;
                    end
                    x_nxt  = 11'd0;
                    y_nxt  = y + 11'd1;
                    we_nxt = 1'b1;
                    wx     = 11'd0;
                    wy     = y + 11'd1;
                end
            end else if ((y == 11'd0 && x_inc == ROW_LIMIT) ||
                         (y != 11'd0 && x_inc >= width_out)) begin
                // Overlong row: drop the pixel and hold x until the next jump.
                err_nxt = 1'b1;
            end else begin
                x_nxt  = x_inc;
                we_nxt = 1'b1;
                wx     = x_inc;
                wy     = y;
            end

            if (we_nxt && wy == LAST_Y && wx == width_nxt - 11'd1) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x             <= 11'd0;
            y             <= 11'd0;
            width_out     <= 11'd0;
            err_out       <= 1'b0;
            done_out      <= 1'b0;
            busy_out      <= 1'b0;
            ram_we_out    <= 1'b0;
            ram_addr_out  <= '0;
            ram_wdata_out <= '0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            width_out  <= width_nxt;
            err_out    <= err_nxt;
            done_out   <= done_nxt;
            busy_out   <= (state_nxt == CAPTURE);
            ram_we_out <= we_nxt;
            if (we_nxt) begin
                ram_addr_out  <= addr_nxt;
                ram_wdata_out <= wdata_nxt;
            end
        end
    end

endmodule
